// File: rtl/roi_apb_master_if.sv
// Command/response port and APB3 requester bus for roi_apb_master.
// Modport master is the requester side; slave is the command source plus APB completer side.
interface roi_apb_master_if #(
  parameter int unsigned APB_DATA_W = 32,
  parameter int unsigned APB_ADDR_W = 12
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [APB_ADDR_W-1:0] cmd_addr_i;
  logic [APB_DATA_W-1:0] cmd_wdata_i;
  logic                  rsp_valid_o;
  logic [APB_DATA_W-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  busy_o;
  logic [APB_ADDR_W-1:0] apb_paddr_o;
  logic [APB_DATA_W-1:0] apb_pwdata_o;
  logic                  apb_pwrite_o;
  logic                  apb_psel_o;
  logic                  apb_penable_o;
  logic [APB_DATA_W-1:0] apb_prdata_i;
  logic                  apb_pready_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, apb_prdata_i, apb_pready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
           apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, apb_prdata_i, apb_pready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
           apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o
  );
endinterface

// File: rtl/roi_apb_master.sv
// APB3 requester that runs single SETUP/ACCESS transfers for the ROI register slave.
// Optional ACCESS-phase timeout enabled by defining ROI_APB_TIMEOUT_EN.
module roi_apb_master #(
  parameter int unsigned APB_DATA_W     = 32,
  parameter int unsigned APB_ADDR_W     = 12
`ifdef ROI_APB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             clk_i,
  input  logic             arst_i,
  roi_apb_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                r_state,       w_state;
  logic                  r_psel,        w_psel;
  logic                  r_penable,     w_penable;
  logic                  r_pwrite,      w_pwrite;
  logic [APB_ADDR_W-1:0] r_paddr,       w_paddr;
  logic [APB_DATA_W-1:0] r_pwdata,      w_pwdata;
  logic                  r_rsp_valid,   w_rsp_valid;
  logic [APB_DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata;

`ifdef ROI_APB_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;
  logic [WAIT_W-1:0]     r_wait_cnt,    w_wait_cnt;
  logic                  r_rsp_err,     w_rsp_err;
`endif

  // Next-state and next-register values.
  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
`ifdef ROI_APB_TIMEOUT_EN
    w_wait_cnt  = r_wait_cnt;
    w_rsp_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          w_state   = S_SETUP;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_pwrite  = bus.cmd_write_i;
          w_paddr   = bus.cmd_addr_i;
          w_pwdata  = bus.cmd_wdata_i;
        end
      end
      S_SETUP: begin
        w_state   = S_ACCESS;
        w_penable = 1'b1;
`ifdef ROI_APB_TIMEOUT_EN
        w_wait_cnt = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.apb_pready_i) begin
          w_state     = S_IDLE;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : bus.apb_prdata_i;
        end
`ifdef ROI_APB_TIMEOUT_EN
        // Counter holds completed wait cycles; the current one is the last allowed.
        else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state     = S_IDLE;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
        end else begin
          w_wait_cnt = r_wait_cnt + WAIT_W'(1);
        end
`endif
      end
      default: begin
        w_state   = S_IDLE;
        w_psel    = 1'b0;
        w_penable = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef ROI_APB_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
`ifdef ROI_APB_TIMEOUT_EN
      r_wait_cnt  <= w_wait_cnt;
      r_rsp_err   <= w_rsp_err;
`endif
    end
  end

  assign bus.cmd_ready_o   = (r_state == S_IDLE) & ~arst_i;
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.apb_psel_o    = r_psel;
  assign bus.apb_penable_o = r_penable;
  assign bus.apb_pwrite_o  = r_pwrite;
  assign bus.apb_paddr_o   = r_paddr;
  assign bus.apb_pwdata_o  = r_pwdata;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_rdata_o   = r_rsp_rdata;
`ifdef ROI_APB_TIMEOUT_EN
  assign bus.rsp_err_o     = r_rsp_err;
`else
  assign bus.rsp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_roi_apb_master.sv
// Self-checking bench for roi_apb_master: directed cases plus randomized transfers
// against a transaction-level model; timeout cases run when ROI_APB_TIMEOUT_EN is defined.
module tb_roi_apb_master;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 12;
  localparam int          TIMEOUT = 16;

  logic clk;
  logic arst;
  int   checks;
  int   failures;

  roi_apb_master_if #(.APB_DATA_W(DW), .APB_ADDR_W(AW)) bus ();

  roi_apb_master #(.APB_DATA_W(DW), .APB_ADDR_W(AW)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
    end
  endtask

  // One transfer starting at a negedge with the DUT idle; plays the APB completer
  // (ready after 'waits' stalled ACCESS cycles, or never if 'stuck') and checks
  // the observed transfer against what the command should produce.
  task automatic do_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic [DW-1:0] prdata, input logic stuck);
    int n_psel, n_pen, n_busy, lat, n_acc;
    logic got, unstable, bad_pen, rsp_err, rdy_at_rsp;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0, rsp_rdata;
    logic w0;
    n_acc = stuck ? TIMEOUT : waits + 1;
    n_psel = 0; n_pen = 0; n_busy = 0; lat = 0;
    got = 1'b0; unstable = 1'b0; bad_pen = 1'b0; rsp_err = 1'b0; rdy_at_rsp = 1'b0;
    a0 = '0; d0 = '0; w0 = 1'b0; rsp_rdata = '0;

    chk(tag, "cmd_ready_start", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_write_i  = wr;
    bus.cmd_addr_i   = addr;
    bus.cmd_wdata_i  = wdata;
    bus.apb_pready_i = 1'($urandom);
    bus.apb_prdata_i = $urandom;

    for (int k = 1; k <= 64 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy_o) n_busy++;
      if (bus.apb_penable_o && !bus.apb_psel_o) bad_pen = 1'b1;
      if (bus.apb_psel_o) begin
        n_psel++;
        if (n_psel == 1) begin
          a0 = bus.apb_paddr_o; d0 = bus.apb_pwdata_o; w0 = bus.apb_pwrite_o;
        end else if (bus.apb_paddr_o !== a0 || bus.apb_pwdata_o !== d0 || bus.apb_pwrite_o !== w0) begin
          unstable = 1'b1;
        end
      end
      if (bus.apb_penable_o) n_pen++;
      if (bus.rsp_valid_o) begin
        got = 1'b1; lat = k;
        rsp_rdata = bus.rsp_rdata_o; rsp_err = bus.rsp_err_o; rdy_at_rsp = bus.cmd_ready_o;
      end
      // Garbage commands while busy must be ignored.
      if (bus.busy_o) begin
        bus.cmd_valid_i = 1'($urandom);
        bus.cmd_write_i = 1'($urandom);
        bus.cmd_addr_i  = AW'($urandom);
        bus.cmd_wdata_i = $urandom;
      end else begin
        bus.cmd_valid_i = 1'b0;
      end
      if (bus.apb_psel_o && bus.apb_penable_o) begin
        bus.apb_pready_i = !stuck && (n_pen - 1 == waits);
        bus.apb_prdata_i = bus.apb_pready_i ? prdata : $urandom;
      end else begin
        bus.apb_pready_i = 1'($urandom);
        bus.apb_prdata_i = $urandom;
      end
    end

    chk(tag, "rsp_seen",   32'(got),       32'd1);
    chk(tag, "latency",    32'(lat),       32'(n_acc + 2));
    chk(tag, "psel_cyc",   32'(n_psel),    32'(n_acc + 1));
    chk(tag, "pen_cyc",    32'(n_pen),     32'(n_acc));
    chk(tag, "busy_cyc",   32'(n_busy),    32'(n_acc + 1));
    chk(tag, "stable",     32'(unstable),  32'd0);
    chk(tag, "pen_no_sel", 32'(bad_pen),   32'd0);
    chk(tag, "paddr",      32'(a0),        32'(addr));
    chk(tag, "pwdata",     d0,             wdata);
    chk(tag, "pwrite",     32'(w0),        32'(wr));
    chk(tag, "rsp_rdata",  rsp_rdata,      (wr || stuck) ? 32'd0 : prdata);
    chk(tag, "rsp_err",    32'(rsp_err),   32'(stuck));
    chk(tag, "ready_rsp",  32'(rdy_at_rsp), 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    arst = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_write_i  = 1'b0;
    bus.cmd_addr_i   = '0;
    bus.cmd_wdata_i  = '0;
    bus.apb_pready_i = 1'b0;
    bus.apb_prdata_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset", "psel",      32'(bus.apb_psel_o),    32'd0);
    chk("reset", "penable",   32'(bus.apb_penable_o), 32'd0);
    chk("reset", "pwrite",    32'(bus.apb_pwrite_o),  32'd0);
    chk("reset", "paddr",     32'(bus.apb_paddr_o),   32'd0);
    chk("reset", "pwdata",    bus.apb_pwdata_o,       32'd0);
    chk("reset", "rsp_valid", 32'(bus.rsp_valid_o),   32'd0);
    chk("reset", "rsp_err",   32'(bus.rsp_err_o),     32'd0);
    chk("reset", "rsp_rdata", bus.rsp_rdata_o,        32'd0);
    chk("reset", "busy",      32'(bus.busy_o),        32'd0);
    chk("reset", "cmd_ready", 32'(bus.cmd_ready_o),   32'd0);
    arst = 1'b0;
    #1;
    chk("reset", "cmd_ready_rel", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk);

    // Directed transfers
    do_xfer("wr_zw",   1'b1, 12'h000, 32'h00C8_00C8, 0, 32'h0, 1'b0);
    do_xfer("wr_wait", 1'b1, 12'h000, 32'h0190_00C8, 3, 32'h0, 1'b0);
    do_xfer("rd_zw",   1'b0, 12'h000, 32'hDEAD_BEEF, 0, 32'h0190_00C8, 1'b0);

    // Back-to-back zero-wait writes: each starts in the response cycle of the previous
    do_xfer("b2b0", 1'b1, 12'h004, 32'h1111_1111, 0, 32'h0, 1'b0);
    do_xfer("b2b1", 1'b1, 12'h008, 32'h2222_2222, 0, 32'h0, 1'b0);
    do_xfer("b2b2", 1'b1, 12'h00C, 32'h3333_3333, 0, 32'h0, 1'b0);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b", "rsp_pulse_end", 32'(bus.rsp_valid_o), 32'd0);
    chk("b2b", "idle",          32'(bus.busy_o),      32'd0);

    // Reset during ACCESS
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_write_i  = 1'b0;
    bus.cmd_addr_i   = 12'h010;
    bus.cmd_wdata_i  = 32'h5555_AAAA;
    bus.apb_pready_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid", "in_access", 32'(bus.apb_penable_o), 32'd1);
    arst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid", "psel",      32'(bus.apb_psel_o),    32'd0);
    chk("rst_mid", "penable",   32'(bus.apb_penable_o), 32'd0);
    chk("rst_mid", "rsp_valid", 32'(bus.rsp_valid_o),   32'd0);
    chk("rst_mid", "busy",      32'(bus.busy_o),        32'd0);
    chk("rst_mid", "paddr",     32'(bus.apb_paddr_o),   32'd0);
    chk("rst_mid", "cmd_ready", 32'(bus.cmd_ready_o),   32'd0);
    arst = 1'b0;
    bus.apb_pready_i = 1'b1;
    #1;
    chk("rst_mid", "cmd_ready_rel", 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rst_mid", "no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    do_xfer("post_rst", 1'b0, 12'h014, 32'h0, 1, 32'hCAFE_0123, 1'b0);

`ifdef ROI_APB_TIMEOUT_EN
    // Timeout, last-cycle ready wins, then recovery
    do_xfer("tmo_stuck", 1'b0, 12'h020, 32'h0, 0, 32'hFFFF_FFFF, 1'b1);
    do_xfer("tmo_edge",  1'b0, 12'h024, 32'h0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0);
    do_xfer("tmo_after", 1'b1, 12'h028, 32'h1234_5678, 2, 32'h0, 1'b0);
`endif

    // Randomized transfers with occasional idle gaps
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("rand_gap", "rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      end
      do_xfer("rand", 1'($urandom), AW'($urandom), $urandom,
              int'($urandom_range(0, 5)), $urandom, 1'b0);
    end
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
